// File: rtl/ascon_pack.sv
// Shared ASCON definitions: state type, round-count type and round-constant table.
// Word x0 occupies bits [319:256] and x4 occupies bits [63:0].
package ascon_pack;

   typedef logic [319:0] type_state;
   typedef logic [3:0]   round_cnt_t;

   localparam round_cnt_t MAX_ROUNDS = 4'd12;

   // c_i = {~i, i}; entries 12..15 are never enabled and stay zero
   localparam logic [15:0][7:0] ROUND_CONST = {
      8'h00, 8'h00, 8'h00, 8'h00,
      8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96,
      8'ha5, 8'hb4, 8'hc3, 8'hd2, 8'he1, 8'hf0
   };

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fsm_e;

   function automatic logic [63:0] ror64(input logic [63:0] x, input logic [6:0] n);
      return (x >> n) | (x << (7'd64 - n));
   endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, bitsliced S-box, linear diffusion.
// When en_i is low the state passes through untouched.
module ascon_round
   import ascon_pack::*;
(
   input  type_state  state_i,
   input  round_cnt_t round_i,
   input  logic       en_i,
   output type_state  state_o
);

   logic [63:0] x0, x1, x2, x3, x4;
   logic [63:0] t0, t1, t2, t3, t4;
   logic [63:0] y0, y1, y2, y3, y4;

   always_comb begin
      x0 = state_i[319:256];
      x1 = state_i[255:192];
      x2 = state_i[191:128] ^ {56'h0, ROUND_CONST[round_i]};
      x3 = state_i[127:64];
      x4 = state_i[63:0];

      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;

      y0 = x0 ^ ror64(x0, 7'd19) ^ ror64(x0, 7'd28);
      y1 = x1 ^ ror64(x1, 7'd61) ^ ror64(x1, 7'd39);
      y2 = x2 ^ ror64(x2, 7'd1)  ^ ror64(x2, 7'd6);
      y3 = x3 ^ ror64(x3, 7'd10) ^ ror64(x3, 7'd17);
      y4 = x4 ^ ror64(x4, 7'd7)  ^ ror64(x4, 7'd41);

      if (en_i) begin
         state_o = {y0, y1, y2, y3, y4};
      end else begin
         state_o = state_i;
      end
   end

endmodule

// File: rtl/ascon_permutation_engine.sv
// Iterative ASCON permutation applying UNROLL rounds per clock over the last nr of 12 rounds.
// rnd_q holds the index of the next round to apply; it saturates at MAX_ROUNDS.
module ascon_permutation_engine
   import ascon_pack::*;
#(
   parameter int UNROLL = 1
) (
   input  logic      clock_i,
   input  logic      resetb_i,
   input  logic      start_i,
   input  logic [3:0] nrounds_i,
   input  type_state state_i,
   output logic      busy_o,
   output logic      done_o,
   output type_state state_o
);

   fsm_e       fsm_q, fsm_d;
   round_cnt_t rnd_q, rnd_d;
   type_state  state_q, state_d;
   logic       done_q, done_d;

   round_cnt_t nr_s;
   round_cnt_t base_s;
   logic [4:0] next_s;
   round_cnt_t next_sat_s;
   logic       last_s;
   type_state  chain_s [UNROLL+1];
   round_cnt_t idx_s   [UNROLL];

   assign nr_s       = (nrounds_i > MAX_ROUNDS) ? MAX_ROUNDS : nrounds_i;
   assign base_s     = (fsm_q == RUN) ? rnd_q : (MAX_ROUNDS - nr_s);
   assign chain_s[0] = (fsm_q == RUN) ? state_q : state_i;
   assign next_s     = {1'b0, base_s} + 5'(UNROLL);
   assign last_s     = (next_s >= {1'b0, MAX_ROUNDS});
   assign next_sat_s = last_s ? MAX_ROUNDS : next_s[3:0];

   // Stages whose round index runs past 11 are bypassed, covering partial groups
   for (genvar g = 0; g < UNROLL; g++) begin : g_round
      assign idx_s[g] = base_s + 4'(g);
      ascon_round u_round (
         .state_i (chain_s[g]),
         .round_i (idx_s[g]),
         .en_i    (idx_s[g] < MAX_ROUNDS),
         .state_o (chain_s[g+1])
      );
   end

   // Next-state logic: accept in IDLE, advance in RUN, pulse done on the final group
   always_comb begin
      fsm_d   = fsm_q;
      rnd_d   = rnd_q;
      state_d = state_q;
      done_d  = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (start_i) begin
               state_d = chain_s[UNROLL];
               rnd_d   = next_sat_s;
               if (last_s) begin
                  fsm_d  = IDLE;
                  done_d = 1'b1;
               end else begin
                  fsm_d  = RUN;
                  done_d = 1'b0;
               end
            end else begin
               fsm_d   = IDLE;
               state_d = state_q;
            end
         end
         RUN: begin
            state_d = chain_s[UNROLL];
            rnd_d   = next_sat_s;
            if (last_s) begin
               fsm_d  = IDLE;
               done_d = 1'b1;
            end else begin
               fsm_d  = RUN;
               done_d = 1'b0;
            end
         end
         default: begin
            fsm_d   = IDLE;
            rnd_d   = 4'd0;
            state_d = '0;
            done_d  = 1'b0;
         end
      endcase
   end

   // State, counter and done registers
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         fsm_q   <= IDLE;
         rnd_q   <= 4'd0;
         state_q <= '0;
         done_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         rnd_q   <= rnd_d;
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   assign busy_o  = (fsm_q == RUN);
   assign done_o  = done_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Directed bench for ascon_permutation_engine at UNROLL = 1, 3 and 4 against a table-driven ASCON model.
module tb_ascon_permutation_engine;
   import ascon_pack::*;

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

   localparam type_state S_IV = {64'h80400c0600000000, 256'h0};
   localparam type_state R1 = {64'h0123456789abcdef, 64'hfedcba9876543210,
                               64'h0f1e2d3c4b5a6978, 64'h8877665544332211, 64'hdeadbeefcafef00d};
   localparam type_state R2 = {64'h243f6a8885a308d3, 64'h13198a2e03707344,
                               64'ha4093822299f31d0, 64'h082efa98ec4e6c89, 64'h452821e638d01377};
   localparam type_state R3 = {64'hb7e151628aed2a6a, 64'hbf7158809cf4f3c7,
                               64'h62e7160f38b4da56, 64'ha784d9045190cfef, 64'h324e7738926cfbe5};

   logic      clk = 1'b0;
   logic      rst_n;
   logic      start   [3];
   logic [3:0] nr     [3];
   type_state st_in   [3];
   logic      busy    [3];
   logic      done    [3];
   type_state st_out  [3];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ascon_permutation_engine #(.UNROLL(1)) u_u1 (
      .clock_i(clk), .resetb_i(rst_n), .start_i(start[0]), .nrounds_i(nr[0]),
      .state_i(st_in[0]), .busy_o(busy[0]), .done_o(done[0]), .state_o(st_out[0]));
   ascon_permutation_engine #(.UNROLL(3)) u_u3 (
      .clock_i(clk), .resetb_i(rst_n), .start_i(start[1]), .nrounds_i(nr[1]),
      .state_i(st_in[1]), .busy_o(busy[1]), .done_o(done[1]), .state_o(st_out[1]));
   ascon_permutation_engine #(.UNROLL(4)) u_u4 (
      .clock_i(clk), .resetb_i(rst_n), .start_i(start[2]), .nrounds_i(nr[2]),
      .state_i(st_in[2]), .busy_o(busy[2]), .done_o(done[2]), .state_o(st_out[2]));

   function automatic logic [63:0] rot(input logic [63:0] a, input int n);
      return (a >> n) | (a << (64 - n));
   endfunction

   function automatic type_state ascon_ref(input type_state s, input int nrr);
      logic [63:0] x [5];
      logic [4:0]  v, o;
      logic [3:0]  ri;
      for (int w = 0; w < 5; w++) x[w] = s[319-64*w -: 64];
      for (int r = 12 - nrr; r < 12; r++) begin
         ri = r[3:0];
         x[2] = x[2] ^ {56'h0, ~ri, ri};
         for (int b = 0; b < 64; b++) begin
            v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            o = SBOX[v];
            x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
         end
         x[0] = x[0] ^ rot(x[0], 19) ^ rot(x[0], 28);
         x[1] = x[1] ^ rot(x[1], 61) ^ rot(x[1], 39);
         x[2] = x[2] ^ rot(x[2], 1)  ^ rot(x[2], 6);
         x[3] = x[3] ^ rot(x[3], 10) ^ rot(x[3], 17);
         x[4] = x[4] ^ rot(x[4], 7)  ^ rot(x[4], 41);
      end
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic launch(input int i, input logic [3:0] n, input type_state s);
      start[i] = 1'b1;
      nr[i]    = n;
      st_in[i] = s;
   endtask

   // Called just before the accept edge; pulse_at > 0 injects a start while busy
   task automatic run_to_done(input int i, input string tag, input int k,
                              input type_state exp, input int pulse_at);
      int c;
      @(posedge clk); #1;
      start[i] = 1'b0;
      c = 1;
      while (!done[i] && c < 40) begin
         if (c == pulse_at) begin
            start[i] = 1'b1;
            nr[i]    = 4'd1;
            st_in[i] = {10{32'hdeadbeef}};
         end else begin
            start[i] = 1'b0;
         end
         @(posedge clk); #1;
         c++;
      end
      start[i] = 1'b0;
      chk({tag, " latency"}, c, k);
      chk({tag, " state"}, st_out[i], exp);
      chk({tag, " busy at done"}, busy[i], 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0; nr[i] = 4'd0; st_in[i] = '0;
      end
      #12;
      for (int i = 0; i < 3; i++) begin
         chk("reset busy", busy[i], 1'b0);
         chk("reset done", done[i], 1'b0);
         chk("reset state", st_out[i], '0);
      end
      #5 rst_n = 1'b1;

      // start accepted on the first edge after release
      launch(0, 4'd12, S_IV);
      run_to_done(0, "u1 pa iv", 12, ascon_ref(S_IV, 12), 0);
      @(posedge clk); #1;
      chk("u1 done single pulse", done[0], 1'b0);

      launch(2, 4'd6, R1);
      run_to_done(2, "u4 nr6", 2, ascon_ref(R1, 6), 0);
      launch(0, 4'd6, R1);
      run_to_done(0, "u1 nr6", 6, ascon_ref(R1, 6), 0);

      launch(1, 4'd8, R2);
      run_to_done(1, "u3 pb8", 3, ascon_ref(R2, 8), 0);
      launch(1, 4'd3, R3);
      run_to_done(1, "u3 nr3", 1, ascon_ref(R3, 3), 0);
      launch(1, 4'd4, R3);
      run_to_done(1, "u3 nr4", 2, ascon_ref(R3, 4), 0);

      // mid-run start ignored, then back-to-back job launched in the done cycle
      launch(0, 4'd6, R3);
      run_to_done(0, "u1 b2b job1", 6, ascon_ref(R3, 6), 2);
      launch(0, 4'd8, R2);
      run_to_done(0, "u1 b2b job2", 8, ascon_ref(R2, 8), 0);
      launch(2, 4'd12, R1);
      run_to_done(2, "u4 b2b job1", 3, ascon_ref(R1, 12), 1);
      launch(2, 4'd8, R3);
      run_to_done(2, "u4 b2b job2", 2, ascon_ref(R3, 8), 0);

      // reset after 5 of 12 rounds
      launch(0, 4'd12, S_IV);
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("u1 busy mid-run", busy[0], 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid reset state", st_out[0], '0);
      chk("mid reset busy", busy[0], 1'b0);
      chk("mid reset done", done[0], 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (14) begin
         @(posedge clk); #1;
         if (done[0] || busy[0]) seen++;
      end
      chk("no done after reset", seen, 0);
      launch(0, 4'd12, S_IV);
      run_to_done(0, "u1 after reset", 12, ascon_ref(S_IV, 12), 0);

      // pass-through and clamping
      launch(2, 4'd0, R2);
      run_to_done(2, "u4 nr0", 1, R2, 0);
      launch(2, 4'd15, R2);
      run_to_done(2, "u4 nr15", 3, ascon_ref(R2, 12), 0);
      launch(0, 4'd0, R1);
      run_to_done(0, "u1 nr0", 1, R1, 0);
      launch(0, 4'd15, R1);
      run_to_done(0, "u1 nr15", 12, ascon_ref(R1, 12), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
